// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth sequential multiplier.
// BOOTH_MULT_SIGNED_EN selects two's-complement operands (default: unsigned).
package booth_pkg;

    typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} digit_e;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    // Unsigned operands need one extra digit to cover the zero-extended top bits.
    function automatic int booth_ndig(input int width);
`ifdef BOOTH_MULT_SIGNED_EN
        return width / 2;
`else
        return width / 2 + 1;
`endif
    endfunction

    function automatic digit_e booth_decode(input logic [2:0] win);
        case (win)
            3'b001, 3'b010: return POS1;
            3'b011:         return POS2;
            3'b100:         return NEG2;
            3'b101, 3'b110: return NEG1;
            default:        return ZERO;
        endcase
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational radix-4 Booth partial product from a 3-bit window and M.
// BOOTH_MULT_SIGNED_EN selects sign- vs zero-extension of M.
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]         win,
    input  logic [WIDTH-1:0]   m,
    output logic [2*WIDTH-1:0] pp
);

    logic [2*WIDTH-1:0] m_ext;

    always_comb begin
`ifdef BOOTH_MULT_SIGNED_EN
        m_ext = {{WIDTH{m[WIDTH-1]}}, m};
`else
        m_ext = {{WIDTH{1'b0}}, m};
`endif
        pp = '0;
        case (booth_decode(win))
            POS1:    pp = m_ext;
            POS2:    pp = m_ext << 1;
            NEG1:    pp = ~m_ext + 1'b1;
            NEG2:    pp = ~(m_ext << 1) + 1'b1;
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_seq_mult.sv
// Radix-4 Booth sequential multiplier, one digit per cycle, done pulse after NDIG busy cycles.
// BOOTH_MULT_SIGNED_EN selects signed operands; default build is unsigned.
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int NDIG = booth_ndig(WIDTH);
    localparam int CW   = $clog2(NDIG + 1);
    localparam int PW   = 2 * WIDTH;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    // {ext[1:0], Q, Q[-1]}; bits [2:0] are always the current digit window
    logic [WIDTH+2:0] q_q, q_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    pp;
    logic [PW-1:0]    acc_sum;
    logic [1:0]       q_ext;

    booth_pp_gen #(.WIDTH(WIDTH)) u_pp_gen (
        .win (q_q[2:0]),
        .m   (m_q),
        .pp  (pp)
    );

`ifdef BOOTH_MULT_SIGNED_EN
    assign q_ext = {2{multiplier[WIDTH-1]}};
`else
    assign q_ext = 2'b00;
`endif

    assign acc_sum = acc_q + (pp << {cnt_q, 1'b0});

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        q_d     = q_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        case (state_q)
            BUSY: begin
                acc_d = acc_sum;
                q_d   = {{2{q_q[WIDTH+2]}}, q_q[WIDTH+2:2]};
                if (cnt_q == CW'(NDIG - 1)) begin
                    prod_d  = acc_sum;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                if (start) begin
                    state_d = BUSY;
                    m_d     = multiplicand;
                    q_d     = {q_ext, multiplier, 1'b0};
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            q_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            q_q     <= q_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign busy    = (state_q == BUSY);
    assign done    = (state_q == DONE);
    assign product = prod_q;

endmodule

// File: doc/booth_seq_mult.md
BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

Interface
REQ-001 Parameter WIDTH, default 8, even and >= 4; operand width in bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
REQ-004 start  input  1  request to begin a multiply; sampled only when not busy.
REQ-005 multiplicand  input  WIDTH  operand M; captured on accepted start.
REQ-006 multiplier  input  WIDTH  operand Q; captured on accepted start and consumed as radix-4 Booth digits.
REQ-007 busy  output  1  high while digits are being accumulated.
REQ-008 done  output  1  single-cycle pulse when product becomes valid.
REQ-009 product  output  2*WIDTH  result; held stable from done until the next accepted start.

Function
REQ-010 States: IDLE, BUSY, DONE; IDLE->BUSY on start; BUSY->DONE after the last digit; DONE->IDLE the following cycle, or DONE->BUSY if start is high in DONE.
REQ-011 Start is accepted in IDLE or DONE only; start while busy=1 is ignored and does not alter captured operands or the digit counter.
REQ-012 Digit i is built from multiplier bits {Q[2i+1], Q[2i], Q[2i-1]}, with Q[-1]=0 and bits above the operand extended per REQ-024/REQ-025.
REQ-013 Digit recoding: 000->0, 001->+M, 010->+M, 011->+2M, 100->-2M, 101->-M, 110->-M, 111->0.
REQ-014 Each partial product is extended to 2*WIDTH bits, shifted left by 2i and added modulo 2^(2*WIDTH) into the accumulator.
REQ-015 Negation is formed as bitwise inversion plus one at full 2*WIDTH width.
REQ-016 One digit is processed per clock cycle; NDIG digits in total, as set in Configuration.
REQ-017 Latency: start accepted at edge t; busy is high for cycles t+1..t+NDIG; done=1 and product valid at cycle t+NDIG+1.
REQ-018 The accumulator is cleared on accepted start, so a back-to-back start in DONE never mixes results.
REQ-019 product is updated only on the DONE transition; it does not expose intermediate sums.
REQ-020 Operand zero, or M equal to the most-negative value, produces the exact modular result with no special handling.

Reset
REQ-021 On rst_n low, asynchronously: state=IDLE, busy=0, done=0, product=0, accumulator and digit counter=0.
REQ-022 Reset asserted mid-operation aborts the multiply; no done pulse is produced for the aborted operation.
REQ-023 After rst_n deasserts, the first rising edge with start=1 is accepted normally.

Configuration
REQ-024 Macro BOOTH_MULT_SIGNED_EN defined: operands are two's complement; sign-extend M; NDIG=WIDTH/2; product is the signed 2*WIDTH result.
REQ-025 Macro BOOTH_MULT_SIGNED_EN undefined: operands are unsigned; zero-extend M and Q by 2 bits; NDIG=WIDTH/2+1; product is the unsigned 2*WIDTH result.

Structure
REQ-026 Shared package booth_pkg holds the digit enumeration (ZERO, POS1, POS2, NEG1, NEG2), the FSM state type, and an NDIG function of WIDTH.
REQ-027 One combinational sub-module, booth_pp_gen, maps a 3-bit digit window and M to a 2*WIDTH partial product; the sequencer, counter and accumulator live in booth_seq_mult.

Verification
REQ-028 Signed build, WIDTH=8: M=7, Q=-3 (0xFD) -> done at cycle t+5, product=0xFFEB (-21).
REQ-029 Signed build: M=0x80, Q=0x80 -> product=0x4000; M=0x80, Q=0x01 -> product=0xFF80.
REQ-030 Unsigned build, WIDTH=8: M=0xFF, Q=0xFF -> done at cycle t+6, product=0xFE01.
REQ-031 start pulsed mid-BUSY with different operands -> ignored; the original product is delivered at the original cycle.
REQ-032 rst_n pulsed low at busy cycle 2 -> all outputs 0 immediately, no done pulse; a fresh start M=3, Q=5 yields product=15.
REQ-033 Back-to-back: start held high through DONE with M=2, Q=3 then M=4, Q=4 -> product 6, then product 16, each with a single done pulse.
